// File: rtl/avalon_pio_irq_if.sv
`default_nettype none
// ============================================================================
// Module   : avalon_pio_irq_if
// Brief    : Avalon-MM slave bus bundle for the PIO/IRQ peripheral.
// Revision : 1.0
// ============================================================================
interface avalon_pio_irq_if;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata
    );
endinterface
`default_nettype wire

// File: rtl/avalon_pio_irq.sv
`default_nettype none
// ============================================================================
// Module   : avalon_pio_irq
// Brief    : Avalon-MM GPIO with atomic set/clear, input sync, edge capture
//            and maskable level IRQ. Optional debounce via PIO_DEBOUNCE_EN.
// Revision : 1.0
// ============================================================================
module avalon_pio_irq #(
    parameter int              OUT_W      = 8,
    parameter int              IN_W       = 8,
    parameter logic [OUT_W-1:0] RESET_OUT = '0,
    parameter int              DEB_CYCLES = 50000
) (
    input  wire                 clk_clk,
    input  wire                 reset_reset_n,
    avalon_pio_irq_if.slave     avs,
    output logic                irq_irq,
    output logic [OUT_W-1:0]    leds_export,
    input  wire  [IN_W-1:0]     switches_export
);

    localparam logic [2:0] C_ADDR_DATA_OUT  = 3'd0;
    localparam logic [2:0] C_ADDR_DATA_IN   = 3'd1;
    localparam logic [2:0] C_ADDR_IRQ_MASK  = 3'd2;
    localparam logic [2:0] C_ADDR_EDGE_CAP  = 3'd3;
    localparam logic [2:0] C_ADDR_EDGE_MODE = 3'd4;
    localparam logic [2:0] C_ADDR_OUT_SET   = 3'd5;
    localparam logic [2:0] C_ADDR_OUT_CLR   = 3'd6;
    localparam logic [2:0] C_ADDR_ID        = 3'd7;

    localparam logic [7:0]  C_IN_W8  = 8'(IN_W);
    localparam logic [7:0]  C_OUT_W8 = 8'(OUT_W);
    localparam logic [31:0] C_ID     = {16'h5049, C_IN_W8, C_OUT_W8};

    logic [OUT_W-1:0] r_out;
    logic [IN_W-1:0]  r_sync1;
    logic [IN_W-1:0]  r_sync2;
    logic [IN_W-1:0]  w_stable;
    logic [IN_W-1:0]  r_stable_d;
    logic [IN_W-1:0]  r_irq_mask;
    logic [IN_W-1:0]  r_edge_cap;
    logic [1:0]       r_edge_mode;
    logic [31:0]      r_rdata;
    logic             r_irq;

    logic [OUT_W-1:0] w_wdata_out;
    logic [IN_W-1:0]  w_wdata_in;
    logic [IN_W-1:0]  w_rise;
    logic [IN_W-1:0]  w_fall;
    logic [IN_W-1:0]  w_edge;
    logic [IN_W-1:0]  w_cap_clr;
    logic [31:0]      w_rdata;
    logic             w_unused_wdata;

    assign w_wdata_out    = avs.avs_writedata[OUT_W-1:0];
    assign w_wdata_in     = avs.avs_writedata[IN_W-1:0];
    assign w_unused_wdata = ^avs.avs_writedata;

    assign leds_export      = r_out;
    assign irq_irq          = r_irq;
    assign avs.avs_readdata = r_rdata;

    // ------------------------------------------------------------------
    // Output register: plain write, atomic set and atomic clear
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_out <= RESET_OUT;
        end else if (avs.avs_write) begin
            case (avs.avs_address)
                C_ADDR_DATA_OUT: r_out <= w_wdata_out;
                C_ADDR_OUT_SET:  r_out <= r_out | w_wdata_out;
                C_ADDR_OUT_CLR:  r_out <= r_out & ~w_wdata_out;
                default:         r_out <= r_out;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Two-flop synchroniser on the raw pins
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= switches_export;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PIO_DEBOUNCE_EN
    localparam int                 C_CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEB_CYCLES - 1);

    logic [C_CNT_W-1:0] r_cnt [IN_W];
    logic [IN_W-1:0]    r_stable;

    // A bit is accepted only after it disagrees with stable for DEB_CYCLES edges
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_stable <= '0;
            for (int i = 0; i < IN_W; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < IN_W; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == C_CNT_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + C_CNT_W'(1);
                end
            end
        end
    end

    assign w_stable = r_stable;
`else
    logic w_unused_deb;
    assign w_unused_deb = (DEB_CYCLES < 2);
    assign w_stable     = r_sync2;
`endif

    // ------------------------------------------------------------------
    // Edge detection and capture
    // ------------------------------------------------------------------
    assign w_rise = w_stable & ~r_stable_d;
    assign w_fall = ~w_stable & r_stable_d;

    always_comb begin
        w_edge = w_rise | w_fall;
        case (r_edge_mode)
            2'b00:   w_edge = w_rise;
            2'b01:   w_edge = w_fall;
            default: w_edge = w_rise | w_fall;
        endcase
    end

    assign w_cap_clr = (avs.avs_write && (avs.avs_address == C_ADDR_EDGE_CAP))
                       ? w_wdata_in : '0;

    // New edges are OR-ed in after the W1C so a colliding edge is kept
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_stable_d <= '0;
            r_edge_cap <= '0;
        end else begin
            r_stable_d <= w_stable;
            r_edge_cap <= (r_edge_cap & ~w_cap_clr) | w_edge;
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_irq_mask  <= '0;
            r_edge_mode <= 2'b00;
        end else if (avs.avs_write) begin
            if (avs.avs_address == C_ADDR_IRQ_MASK) begin
                r_irq_mask <= w_wdata_in;
            end
            if (avs.avs_address == C_ADDR_EDGE_MODE) begin
                r_edge_mode <= avs.avs_writedata[1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path: registered, reflects pre-write state on a read+write cycle
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        case (avs.avs_address)
            C_ADDR_DATA_OUT:  w_rdata[OUT_W-1:0] = r_out;
            C_ADDR_DATA_IN:   w_rdata[IN_W-1:0]  = w_stable;
            C_ADDR_IRQ_MASK:  w_rdata[IN_W-1:0]  = r_irq_mask;
            C_ADDR_EDGE_CAP:  w_rdata[IN_W-1:0]  = r_edge_cap;
            C_ADDR_EDGE_MODE: w_rdata[1:0]       = r_edge_mode;
            C_ADDR_ID:        w_rdata            = C_ID;
            default:          w_rdata            = '0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_rdata <= '0;
        end else if (avs.avs_read) begin
            r_rdata <= w_rdata;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_edge_cap & r_irq_mask);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_avalon_pio_irq.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_pio_irq
// Brief    : Directed, table-driven self-checking bench for avalon_pio_irq.
// Revision : 1.0
// ============================================================================
module tb_avalon_pio_irq;

`ifdef PIO_DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       irq;
    logic [7:0] leds;
    logic [7:0] sw = 8'h00;

    int checks = 0;
    int errors = 0;

    avalon_pio_irq_if bus ();

    avalon_pio_irq #(
        .OUT_W      (8),
        .IN_W       (8),
        .RESET_OUT  (8'hA5),
        .DEB_CYCLES (4)
    ) dut (
        .clk_clk         (clk),
        .reset_reset_n   (rst_n),
        .avs             (bus),
        .irq_irq         (irq),
        .leds_export     (leds),
        .switches_export (sw)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_write     = 1'b0;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        @(negedge clk);
        bus.avs_read    = 1'b0;
        d = bus.avs_readdata;
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        bit          found;

        bus.avs_address   = 3'd0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = 32'h0;

        // {wr, addr, data, expected: leds after write / readdata after read}
        vecs[0]  = '{1'b0, 3'd7, 32'h0,       32'h5049_0808};
        vecs[1]  = '{1'b0, 3'd0, 32'h0,       32'h0000_00A5};
        vecs[2]  = '{1'b1, 3'd0, 32'h0000_000F, 32'h0000_000F};
        vecs[3]  = '{1'b1, 3'd5, 32'h0000_00C0, 32'h0000_00CF};
        vecs[4]  = '{1'b1, 3'd6, 32'h0000_0003, 32'h0000_00CC};
        vecs[5]  = '{1'b0, 3'd5, 32'h0,       32'h0000_0000};
        vecs[6]  = '{1'b0, 3'd6, 32'h0,       32'h0000_0000};
        vecs[7]  = '{1'b0, 3'd0, 32'h0,       32'h0000_00CC};
        vecs[8]  = '{1'b1, 3'd2, 32'h0000_0FFF, 32'h0000_00CC};
        vecs[9]  = '{1'b0, 3'd2, 32'h0,       32'h0000_00FF};
        vecs[10] = '{1'b1, 3'd2, 32'h0000_0001, 32'h0000_00CC};
        vecs[11] = '{1'b1, 3'd4, 32'h0000_0007, 32'h0000_00CC};
        vecs[12] = '{1'b0, 3'd4, 32'h0,       32'h0000_0003};
        vecs[13] = '{1'b1, 3'd4, 32'h0,       32'h0000_00CC};
        vecs[14] = '{1'b0, 3'd4, 32'h0,       32'h0000_0000};
        vecs[15] = '{1'b0, 3'd1, 32'h0,       32'h0000_0000};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_leds", {24'h0, leds}, 32'hA5);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_rdata", bus.avs_readdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_leds", {24'h0, leds}, 32'hA5);

        // Register map vectors
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) begin
                wr_reg(vecs[i].addr, vecs[i].data);
                check($sformatf("vec%0d_leds", i), {24'h0, leds}, vecs[i].exp);
            end else begin
                rd_reg(vecs[i].addr, rd);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
            end
        end

        // Simultaneous read and write: read sees the old value
        @(negedge clk);
        bus.avs_address   = 3'd0;
        bus.avs_writedata = 32'h55;
        bus.avs_read      = 1'b1;
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        check("rw_rdata", bus.avs_readdata, 32'hCC);
        check("rw_leds", {24'h0, leds}, 32'h55);
        repeat (3) @(negedge clk);
        check("rdata_hold", bus.avs_readdata, 32'hCC);

        // Rising-edge interrupt on bit0 (mask=01, mode=rising)
        @(negedge clk);
        sw[0] = 1'b1;
        found = 1'b0;
        for (int n = 0; n < LAT + 2 && !found; n++) begin
            @(negedge clk);
            if (irq) found = 1'b1;
        end
        check("irq_rise", {31'h0, found}, 32'h1);
        rd_reg(3'd3, rd);
        check("cap_bit0", rd, 32'h01);
        rd_reg(3'd1, rd);
        check("data_in_bit0", rd, 32'h01);
        wr_reg(3'd3, 32'h1);
        check("irq_lag_w1c", {31'h0, irq}, 32'h1);
        @(negedge clk);
        check("irq_clr", {31'h0, irq}, 32'h0);

        // Falling mode, masked bit3
        wr_reg(3'd4, 32'h1);
        @(negedge clk);
        sw[3] = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        rd_reg(3'd3, rd);
        check("fall_ignores_rise", rd, 32'h00);
        @(negedge clk);
        sw[3] = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        rd_reg(3'd3, rd);
        check("cap_bit3_fall", rd, 32'h08);
        check("irq_masked", {31'h0, irq}, 32'h0);
        wr_reg(3'd2, 32'h09);
        check("irq_mask_lag", {31'h0, irq}, 32'h0);
        @(negedge clk);
        check("irq_unmasked", {31'h0, irq}, 32'h1);

        // W1C colliding with a new rising edge on bit2
        wr_reg(3'd2, 32'h01);
        wr_reg(3'd3, 32'hFF);
        wr_reg(3'd4, 32'h0);
        rd_reg(3'd3, rd);
        check("cap_cleared", rd, 32'h00);
        @(negedge clk);
        sw[2] = 1'b1;
        repeat (LAT) @(negedge clk);
        bus.avs_address   = 3'd3;
        bus.avs_writedata = 32'h04;
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_write     = 1'b0;
        rd_reg(3'd3, rd);
        check("collision_set_wins", rd, 32'h04);
        wr_reg(3'd3, 32'h04);
        rd_reg(3'd3, rd);
        check("w1c_bit2", rd, 32'h00);

`ifdef PIO_DEBOUNCE_EN
        // Short glitch rejected, long hold accepted after 2+DEB_CYCLES edges
        wr_reg(3'd2, 32'h0);
        rd_reg(3'd1, rd);
        check("deb_base", rd, 32'h05);
        @(negedge clk);
        sw[1] = 1'b1;
        repeat (3) @(negedge clk);
        sw[1] = 1'b0;
        repeat (10) @(negedge clk);
        rd_reg(3'd1, rd);
        check("deb_glitch_in", rd, 32'h05);
        rd_reg(3'd3, rd);
        check("deb_glitch_cap", rd, 32'h00);
        @(negedge clk);
        sw[1] = 1'b1;
        repeat (5) @(negedge clk);
        bus.avs_address = 3'd1;
        bus.avs_read    = 1'b1;
        @(negedge clk);
        check("deb_edge5", bus.avs_readdata, 32'h05);
        @(negedge clk);
        bus.avs_read    = 1'b0;
        check("deb_edge6", bus.avs_readdata, 32'h07);
`endif

        // Asynchronous reset while the interrupt is pending
        wr_reg(3'd0, 32'h3C);
        check("leds_pre_rst", {24'h0, leds}, 32'h3C);
        wr_reg(3'd4, 32'h2);
        wr_reg(3'd2, 32'h04);
        @(negedge clk);
        sw[2] = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        check("irq_pre_rst", {31'h0, irq}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_irq", {31'h0, irq}, 32'h0);
        check("async_rst_leds", {24'h0, leds}, 32'hA5);
        sw = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        rd_reg(3'd2, rd);
        check("rst_mask", rd, 32'h00);
        rd_reg(3'd3, rd);
        check("rst_cap", rd, 32'h00);
        check("rst_irq_after", {31'h0, irq}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
